// File: rtl/logic_updown_counter_n_if.sv
// logic_updown_counter_n_if
//   Groups the control, data and cascade signals of one up/down counter stage.
//   Clock (CP) and reset (MR) are plain ports on the counter itself.
//
//   nCE  count enable, active-low
//   nUD  direction, 0 = up, 1 = down
//   nPL  synchronous parallel load, active-low
//   D    parallel load data
//   Q    registered count
//   TC   terminal count (combinational)
//   nRC  ripple carry to the next stage, active-low (combinational)
//
//   master: the stimulus side (drives controls, observes count/cascade)
//   slave : the counter
`timescale 1ns/1ps
interface logic_updown_counter_n_if #(
  parameter int WIDTH = 4
);
  logic             nCE;
  logic             nUD;
  logic             nPL;
  logic [WIDTH-1:0] D;
  logic [WIDTH-1:0] Q;
  logic             TC;
  logic             nRC;

  modport master (output nCE, nUD, nPL, D, input  Q, TC, nRC);
  modport slave  (input  nCE, nUD, nPL, D, output Q, TC, nRC);
endinterface

// File: rtl/logic_updown_counter_n.sv
// logic_updown_counter_n
//   Presettable synchronous binary up/down counter with programmable modulus
//   and cascade outputs. The count cycles 0..MODULUS-1; stages cascade by
//   driving the upper stage's nCE from the lower stage's nRC on a shared CP.
//
//   Parameters
//     WIDTH    counter width in bits (1..32)
//     MODULUS  count range (2..2**WIDTH), default 2**WIDTH
//   Ports
//     CP   clock, rising edge
//     MR   asynchronous active-high clear
//     bus  slave modport: nCE, nUD, nPL, D in; Q, TC, nRC out
//
//   Per-edge priority: MR > nPL > nCE. The only state is the count register.
`timescale 1ns/1ps
module logic_updown_counter_n #(
  parameter int              WIDTH   = 4,
  parameter longint unsigned MODULUS = 64'(1) << WIDTH
) (
  input  logic                             CP,
  input  logic                             MR,
  logic_updown_counter_n_if.slave          bus
);

  // Reject impossible configurations at elaboration time.
  generate
    if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
      $error("logic_updown_counter_n: WIDTH must be 1..32");
    end
    if (MODULUS < 2 || MODULUS > (64'(1) << WIDTH)) begin : g_bad_mod
      $error("logic_updown_counter_n: MODULUS must be 2..2**WIDTH");
    end
  endgenerate

  localparam logic [WIDTH-1:0] MAX  = WIDTH'(MODULUS - 64'(1));
  localparam logic [WIDTH-1:0] ZERO = '0;
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

  logic [WIDTH-1:0] q_q, q_d;
  logic             tc;

  // Next-count selection. A loaded value above MAX is legal; the ">= MAX"
  // (up) and "> MAX" (down) tests pull such a value back into range on the
  // next count instead of letting it run on past the modulus.
  always_comb begin
    q_d = q_q;
    if (!bus.nPL) begin
      q_d = bus.D;
    end else if (!bus.nCE) begin
      if (!bus.nUD) begin
        q_d = (q_q >= MAX) ? ZERO : q_q + ONE;
      end else begin
        q_d = (q_q == ZERO || q_q > MAX) ? MAX : q_q - ONE;
      end
    end
  end

  always_ff @(posedge CP or posedge MR) begin
    if (MR) q_q <= '0;
    else    q_q <= q_d;
  end

  // Terminal count follows the direction input with no clock involved, so a
  // cascade sees the correct carry as soon as nUD or the count changes.
  always_comb begin
    tc = bus.nUD ? (q_q == ZERO) : (q_q == MAX);
  end

  assign bus.Q   = q_q;
  assign bus.TC  = tc;
  assign bus.nRC = ~(tc & ~bus.nCE);

endmodule
